// File: rtl/prefix_adder_pipe_pkg.sv
// Shared ALU definitions for the pipelined prefix adder: lane_log encodings
// and the lane-boundary mask helper.
package prefix_adder_pipe_pkg;

  localparam logic [1:0] LANE_FULL    = 2'd0;
  localparam logic [1:0] LANE_HALF    = 2'd1;
  localparam logic [1:0] LANE_QUARTER = 2'd2;
  localparam logic [1:0] LANE_EIGHTH  = 2'd3;

  // One bit of the lane-boundary mask: 1 when bit_idx is the base of a lane.
  // Lanes narrower than lane_min are clamped up to lane_min.
  function automatic logic lane_mask_bit(input int bit_idx, input logic [1:0] lane_log,
                                         input int width, input int lane_min);
    int lane_w;
    case (lane_log)
      LANE_FULL:    lane_w = width;
      LANE_HALF:    lane_w = width / 2;
      LANE_QUARTER: lane_w = width / 4;
      LANE_EIGHTH:  lane_w = width / 8;
      default:      lane_w = width;
    endcase
    if (lane_w < lane_min) lane_w = lane_min;
    return (bit_idx & (lane_w - 1)) == 0;
  endfunction

endpackage

// File: rtl/prefix_adder_pipe_level.sv
// One masked Kogge-Stone level at distance DIST. s_in marks bits whose
// lookback window already reaches a lane base; those bits pass through.
module prefix_level #(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] s_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] s_out
);

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (gi < DIST) begin : g_pass
      assign g_out[gi] = g_in[gi];
      assign p_out[gi] = p_in[gi];
      assign s_out[gi] = s_in[gi];
    end else begin : g_comb
      assign g_out[gi] = g_in[gi] | (!s_in[gi] & p_in[gi] & g_in[gi-DIST]);
      assign p_out[gi] = p_in[gi] & (s_in[gi] | p_in[gi-DIST]);
      // Segment flag spreads like propagate so later levels see lane bases.
      assign s_out[gi] = s_in[gi] | s_in[gi-DIST];
    end
  end

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined SIMD Kogge-Stone adder/subtractor with whole-pipe stall.
// Define ADDER_FLAGS_EN to add the per-lane cout/ovf outputs.
module prefix_adder_pipe
  import prefix_adder_pipe_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LANE_MIN  = 8,
  parameter int REG_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [1:0]       lane_log,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum
`ifdef ADDER_FLAGS_EN
  ,
  output logic [WIDTH/LANE_MIN-1:0] cout,
  output logic [WIDTH/LANE_MIN-1:0] ovf
`endif
);

  localparam int NL = $clog2(WIDTH);
  localparam int NS = (NL + REG_EVERY - 1) / REG_EVERY;

  genvar gi;

  logic stall;
  logic out_valid_reg;
  logic [WIDTH-1:0] sum_reg, sum_next;

  assign stall     = out_valid_reg && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;

  // Input preparation: invert B for subtract, fold lane carry-in into bit 0 of each lane.
  logic [WIDTH-1:0] b_x, g_in0, p_in0, start_in, cvec_in;
  for (gi = 0; gi < WIDTH; gi++) begin : g_mask
    assign start_in[gi] = lane_mask_bit(gi, lane_log, WIDTH, LANE_MIN);
  end
  assign b_x     = b ^ {WIDTH{sub}};
  assign p_in0   = a ^ b_x;
  assign cvec_in = sub ? start_in : {{(WIDTH-1){1'b0}}, cin};
  assign g_in0   = (a & b_x) | (p_in0 & cvec_in);

  logic [WIDTH-1:0] g_reg     [0:NS-1];
  logic [WIDTH-1:0] p_reg     [0:NS-1];
  logic [WIDTH-1:0] s_reg     [0:NS-1];
  logic [WIDTH-1:0] p0_reg    [0:NS-1];
  logic [WIDTH-1:0] cvec_reg  [0:NS-1];
  logic [WIDTH-1:0] start_reg [0:NS-1];
  logic             v_reg     [0:NS-1];
  logic [WIDTH-1:0] g_next     [0:NS-1];
  logic [WIDTH-1:0] p_next     [0:NS-1];
  logic [WIDTH-1:0] s_next     [0:NS-1];
  logic [WIDTH-1:0] p0_next    [0:NS-1];
  logic [WIDTH-1:0] cvec_next  [0:NS-1];
  logic [WIDTH-1:0] start_next [0:NS-1];
  logic             v_next     [0:NS-1];

  logic [WIDTH-1:0] lg [1:NL];
  logic [WIDTH-1:0] lp [1:NL];
  logic [WIDTH-1:0] ls [1:NL];

  for (gi = 0; gi < NL; gi++) begin : g_level
    logic [WIDTH-1:0] g_l, p_l, s_l;
    if (gi % REG_EVERY == 0) begin : g_from_reg
      assign g_l = g_reg[gi/REG_EVERY];
      assign p_l = p_reg[gi/REG_EVERY];
      assign s_l = s_reg[gi/REG_EVERY];
    end else begin : g_from_wire
      assign g_l = lg[gi];
      assign p_l = lp[gi];
      assign s_l = ls[gi];
    end
    prefix_level #(.WIDTH(WIDTH), .DIST(1 << gi)) u_level (
      .g_in (g_l),
      .p_in (p_l),
      .s_in (s_l),
      .g_out(lg[gi+1]),
      .p_out(lp[gi+1]),
      .s_out(ls[gi+1])
    );
  end

  for (gi = 0; gi < NS; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign g_next[0]     = g_in0;
      assign p_next[0]     = p_in0;
      assign s_next[0]     = start_in;
      assign p0_next[0]    = p_in0;
      assign cvec_next[0]  = cvec_in;
      assign start_next[0] = start_in;
      assign v_next[0]     = in_valid;
    end else begin : g_mid
      assign g_next[gi]     = lg[gi*REG_EVERY];
      assign p_next[gi]     = lp[gi*REG_EVERY];
      assign s_next[gi]     = ls[gi*REG_EVERY];
      assign p0_next[gi]    = p0_reg[gi-1];
      assign cvec_next[gi]  = cvec_reg[gi-1];
      assign start_next[gi] = start_reg[gi-1];
      assign v_next[gi]     = v_reg[gi-1];
    end
  end

  // Carry into a lane base is the lane carry-in; elsewhere it is the group generate below.
  logic [WIDTH-1:0] gf, carry_vec;
  assign gf        = lg[NL];
  assign carry_vec = ({gf[WIDTH-2:0], 1'b0} & ~start_reg[NS-1]) | cvec_reg[NS-1];
  assign sum_next  = p0_reg[NS-1] ^ carry_vec;

  logic unused_last;
  assign unused_last = ^{lp[NL], ls[NL], gf[WIDTH-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        g_reg[i]     <= '0;
        p_reg[i]     <= '0;
        s_reg[i]     <= '0;
        p0_reg[i]    <= '0;
        cvec_reg[i]  <= '0;
        start_reg[i] <= '0;
        v_reg[i]     <= 1'b0;
      end
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
    end else if (!stall) begin
      for (int i = 0; i < NS; i++) begin
        g_reg[i]     <= g_next[i];
        p_reg[i]     <= p_next[i];
        s_reg[i]     <= s_next[i];
        p0_reg[i]    <= p0_next[i];
        cvec_reg[i]  <= cvec_next[i];
        start_reg[i] <= start_next[i];
        v_reg[i]     <= v_next[i];
      end
      out_valid_reg <= v_reg[NS-1];
      sum_reg       <= sum_next;
    end
  end

`ifdef ADDER_FLAGS_EN
  localparam int NLANE = WIDTH / LANE_MIN;
  logic [NLANE-1:0] lane_top, cout_next, ovf_next, cout_reg, ovf_reg;

  // Flags land in the LANE_MIN slot holding each lane's MSB; other slots read 0.
  for (gi = 0; gi < NLANE; gi++) begin : g_flag
    localparam int MSB = gi * LANE_MIN + LANE_MIN - 1;
    if (gi == NLANE - 1) begin : g_last
      assign lane_top[gi] = 1'b1;
    end else begin : g_inner
      assign lane_top[gi] = start_reg[NS-1][MSB+1];
    end
    assign cout_next[gi] = lane_top[gi] & gf[MSB];
    assign ovf_next[gi]  = lane_top[gi] & (carry_vec[MSB] ^ gf[MSB]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cout_reg <= '0;
      ovf_reg  <= '0;
    end else if (!stall) begin
      cout_reg <= cout_next;
      ovf_reg  <= ovf_next;
    end
  end

  assign cout = cout_reg;
  assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Scoreboard bench for prefix_adder_pipe: directed plan vectors, back-pressure,
// mid-flight reset and randomized beats against a per-lane arithmetic model.
module tb_prefix_adder_pipe;

  typedef struct {
    logic [31:0] sum;
    logic [3:0]  cout;
    logic [3:0]  ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic        cin = 1'b0, sub = 1'b0;
  logic [1:0]  lane_log = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
`ifdef ADDER_FLAGS_EN
  logic [3:0]  cout, ovf;
`endif

  prefix_adder_pipe #(.WIDTH(32), .LANE_MIN(8), .REG_EVERY(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .lane_log(lane_log),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
`ifdef ADDER_FLAGS_EN
    , .cout(cout), .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by the test
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Per-lane reference: plain integer add of the lane fields.
  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic mc, input logic ms, input logic [1:0] ml);
    exp_t e;
    int   lw;
    e.sum = '0; e.cout = '0; e.ovf = '0;
    lw = 32 >> ml;
    if (lw < 8) lw = 8;
    for (int base = 0; base < 32; base += lw) begin
      longint unsigned m, av, bv, ci, r;
      int slot;
      m  = (64'd1 << lw) - 64'd1;
      av = ({32'd0, ma} >> base) & m;
      bv = ({32'd0, (ms ? ~mb : mb)} >> base) & m;
      ci = ms ? 64'd1 : ((base == 0 && mc) ? 64'd1 : 64'd0);
      r  = av + bv + ci;
      e.sum = e.sum | 32'((r & m) << base);
      slot = (base + lw) / 8 - 1;
      e.cout[slot] = r[lw];
      e.ovf[slot]  = (av[lw-1] == bv[lw-1]) && (r[lw-1] != av[lw-1]);
    end
    return e;
  endfunction

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                      input logic ts, input logic [1:0] tl, input exp_t e);
    int waited = 0;
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; lane_log = tl; in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end else begin
      exp_q.push_back(e);
    end
  endtask

  task automatic send_rand();
    logic [31:0] ra, rb;
    logic        rc, rs;
    logic [1:0]  rl;
    ra = $urandom; rb = $urandom;
    rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
    rl = 2'($urandom_range(0, 3));
    send(ra, rb, rc, rs, rl, model(ra, rb, rc, rs, rl));
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  task automatic drain();
    int w = 0;
    idle();
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: owns out_ready in modes 0/1, pops and compares on every transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (!rst && out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_output: got sum %h, required no output", sum);
        end else begin
          e = exp_q.pop_front();
          check("sum", 64'(sum), 64'(e.sum));
`ifdef ADDER_FLAGS_EN
          check("cout", 64'(cout), 64'(e.cout));
          check("ovf", 64'(ovf), 64'(e.ovf));
`endif
          n_out++;
          $display("beat %0d: sum=%h expected=%h", n_out, sum, e.sum);
        end
      end
    end
  end

  initial begin
    exp_t e;
    int   cnt;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_sum", 64'(sum), 64'd0);
`ifdef ADDER_FLAGS_EN
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Full-width wrap, with latency measurement
    e.sum = 32'h0000_0000; e.cout = 4'b1000; e.ovf = 4'b0000;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 2'd0, e);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    check("latency", 64'(cnt), 64'd4);
    drain();

    // 4x8-bit lanes, then the same beat with lane_log clamped from eighth
    e.sum = 32'h8002_0000; e.cout = 4'b0011; e.ovf = 4'b1001;
    send(32'h7F01_FF80, 32'h0101_0180, 1'b0, 1'b0, 2'd2, e);
    send(32'h7F01_FF80, 32'h0101_0180, 1'b0, 1'b0, 2'd3, e);
    // 2x16-bit subtract
    e.sum = 32'hFFFF_FFFF; e.cout = 4'b0000; e.ovf = 4'b0000;
    send(32'h0005_0000, 32'h0006_0001, 1'b0, 1'b1, 2'd1, e);
    // cin only enters lane 0
    e.sum = 32'h0000_0100; e.cout = 4'b0000; e.ovf = 4'b0000;
    send(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 2'd1, e);
    drain();

    // Back-pressure: six back-to-back beats, consumer stalls cycles 3..7
    rdy_mode = 2;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) send_rand();
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    rdy_mode = 0;
    drain();

    // Reset with three beats in flight: none may emerge
    for (int i = 0; i < 3; i++) send_rand();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_out_valid", 64'(out_valid), 64'd0);
    end

    // Randomized traffic with random back-pressure and bubbles
    rdy_mode = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) idle();
      send_rand();
    end
    rdy_mode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prefix_adder_pipe.md
# prefix_adder_pipe

Parametrised, pipelined parallel-prefix (Kogge-Stone) adder/subtractor with SIMD lane splitting and a valid/ready handshake on both sides. It generalises the single masked generate/propagate stage into a complete log2(WIDTH)-level prefix network, with a pipeline register after every REG_EVERY levels. It sits in the ALU datapath beside the combinational adder and serves wide and packed-SIMD add/sub operations at high clock rates.

## Interface
- WIDTH, 32: operand width; power of two, ≥ 8.
- LANE_MIN, 8: narrowest SIMD lane width; power of two, ≤ WIDTH.
- REG_EVERY, 2: prefix levels between pipeline registers; 1..log2(WIDTH).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry into lane 0 (add only).
- sub  in  1  1 = A − B per lane.
- lane_log  in  2  lane width = WIDTH >> lane_log; values giving lanes narrower than LANE_MIN are clamped to LANE_MIN.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  per-lane result.
- cout  out  WIDTH/LANE_MIN  per-lane carry-out; present only with ADDER_FLAGS_EN.
- ovf  out  WIDTH/LANE_MIN  per-lane signed overflow; present only with ADDER_FLAGS_EN.

## Operation
- Accept on in_valid && in_ready. Stage 0 registers a, b ^ {WIDTH{sub}}, per-bit g = a&b', p = a^b', the lane-boundary mask, and the per-lane carry-in.
- Lane carry-in: sub ? 1 : (lane 0 ? cin : 0).
- The lane mask clears g/p combination across any lane boundary at every prefix level, so no carry crosses lanes. Carry-in enters as g at bit −1 of each lane, folded into bit 0.
- Prefix level k combines bit i with bit i−2^k within the same lane; bits with i−2^k below the lane base pass through unchanged.
- Output: sum[i] = p0[i] ^ carry[i]. cout = lane-top group generate. ovf = carry into the lane MSB ^ carry out of the lane MSB.
- The pipeline stalls as a whole: stall = out_valid && !out_ready. While stalled, every stage holds; in_ready = !stall. Bubbles are not compressed.
- Each stage carries a valid bit; invalid stages do not drive out_valid.

## Timing
- Latency L = 1 + ceil(log2(WIDTH)/REG_EVERY) cycles from accept to out_valid, when not stalled. With the defaults, L = 4.
- Throughput: 1 beat/cycle while out_ready = 1.
- Reset: every stage valid = 0, out_valid = 0, in_ready = 1, sum = 0, cout = 0, ovf = 0. Data registers are also cleared.
- Reset mid-operation drops all in-flight beats; none appear after rst deasserts.
- When out_ready rises in the same cycle as in_valid, the pipeline advances and the new beat is accepted.
- Results appear in acceptance order; lane_log and sub travel with their beat.

## Configuration
- ADDER_FLAGS_EN defined: cout and ovf ports exist and are pipelined alongside sum.
- ADDER_FLAGS_EN undefined: the ports and their registers are absent; sum behaviour is identical.

## Structure
- Shared ALU package holds:
  - lane_log encoding constants: LANE_FULL = 0, LANE_HALF = 1, LANE_QUARTER = 2, LANE_EIGHTH = 3.
  - A function building the lane-boundary mask from lane_log, WIDTH and LANE_MIN.
- One sub-module, prefix_level, implements a single masked level with distance 2^k, replicated log2(WIDTH) times. Registers are inserted in the parent.

## Test plan
- Full width: a=0xFFFF_FFFF, b=1, cin=0, sub=0 -> sum=0x0000_0000 after 4 cycles; cout[3]=1 (flags on).
- 4×8-bit lanes: a=0x7F01_FF80, b=0x0101_0180, lane_log=2 -> sum=0x8002_0000; no carry crosses lanes; ovf=0b1001, cout=0b0011.
- Subtract, 2×16-bit lanes: a=0x0005_0000, b=0x0006_0001, sub=1 -> sum=0xFFFF_FFFF.
- Back-pressure: 6 back-to-back beats with out_ready=0 from cycle 3 to cycle 7 -> in_ready low while stalled; all 6 results delivered in order, no loss or duplication.
- Reset with 3 beats in flight -> out_valid=0 for ≥ L cycles after reset; none of the 3 beats emerge.
- Random: 10k beats with random a, b, sub, lane_log and out_ready -> matches the per-lane reference model.
